// File: rtl/uart_rx_packet_pkg.sv
// Shared definitions for the framed UART packet receiver: FSM encoding,
// default sync marker, length/address widths and the checksum fold.
package uart_rx_packet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_LEN  = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_GET_CHK  = 3'd3,
    ST_WAIT_ACK = 3'd4
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
  localparam int         LEN_W         = 5;
  localparam int         ADDR_W        = 4;

  function automatic logic [7:0] chk_fold(input logic [7:0] chk, input logic [7:0] data);
    return chk ^ data;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store: one synchronous write port and one registered read port.
// Array contents are never reset; only the read register clears.
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_r [DEPTH];
  logic [7:0] rd_data_r;

  // Payload write port.
  always_ff @(posedge i_Clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; out-of-range addresses keep the last value.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rd_data_r <= 8'd0;
    end else if (int'(rd_addr) < DEPTH) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/uart_rx_packet.sv
// Frame parser on top of a UART byte stream: SYNC, LEN, payload, XOR check.
// Holds one good packet in uart_pkt_buf until the consumer acknowledges it.
module uart_rx_packet
  import uart_rx_packet_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 2170,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_Pkt_Rdy,
  output logic [LEN_W-1:0]  o_Pkt_Len,
  input  logic              i_Pkt_Ack,
  input  logic [ADDR_W-1:0] i_Rd_Addr,
  output logic [7:0]        o_Rd_Data,
  output logic              o_Pkt_Err,
  output logic              o_Overrun
);

  localparam int               TMO_W     = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  rx_state_t          state_r, state_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic [LEN_W-1:0]   idx_r, idx_s;
  logic [7:0]         chk_r, chk_s;
  logic [TMO_W-1:0]   tmo_r, tmo_s;
  logic               err_r, err_s;
  logic               ovr_r, ovr_s;
  logic               rdy_r;
  logic               wr_en_s;
  logic               tmo_hit_s;
  logic               len_ok_s;

  // Next-state and datapath decisions; only strobed bytes advance the frame.
  always_comb begin
    state_s   = state_r;
    len_s     = len_r;
    idx_s     = idx_r;
    chk_s     = chk_r;
    tmo_s     = tmo_r;
    err_s     = 1'b0;
    ovr_s     = 1'b0;
    wr_en_s   = 1'b0;
    tmo_hit_s = (tmo_r == TMO_LAST);
    len_ok_s  = (i_RX_Byte != 8'd0) && (i_RX_Byte <= MAX_LEN_B);
    case (state_r)
      ST_IDLE: begin
        tmo_s = {TMO_W{1'b0}};
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
          state_s = ST_GET_LEN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GET_LEN: begin
        if (i_RX_DV) begin
          tmo_s = {TMO_W{1'b0}};
          if (len_ok_s) begin
            len_s   = i_RX_Byte[LEN_W-1:0];
            chk_s   = i_RX_Byte;
            idx_s   = {LEN_W{1'b0}};
            state_s = ST_GET_DATA;
          end else begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      ST_GET_DATA: begin
        if (i_RX_DV) begin
          tmo_s   = {TMO_W{1'b0}};
          wr_en_s = 1'b1;
          chk_s   = chk_fold(chk_r, i_RX_Byte);
          idx_s   = idx_r + LEN_W'(1);
          if (idx_r == (len_r - LEN_W'(1))) begin
            state_s = ST_GET_CHK;
          end else begin
            state_s = ST_GET_DATA;
          end
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      ST_GET_CHK: begin
        if (i_RX_DV) begin
          tmo_s = {TMO_W{1'b0}};
          if (i_RX_Byte == chk_r) begin
            state_s = ST_WAIT_ACK;
          end else begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        // A byte arriving with the ack is still dropped: the ack wins the state.
        tmo_s = {TMO_W{1'b0}};
        ovr_s = i_RX_DV;
        if (i_Pkt_Ack) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_ACK;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame bookkeeping and registered status outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      len_r <= {LEN_W{1'b0}};
      idx_r <= {LEN_W{1'b0}};
      chk_r <= 8'd0;
      tmo_r <= {TMO_W{1'b0}};
      err_r <= 1'b0;
      ovr_r <= 1'b0;
      rdy_r <= 1'b0;
    end else begin
      len_r <= len_s;
      idx_r <= idx_s;
      chk_r <= chk_s;
      tmo_r <= tmo_s;
      err_r <= err_s;
      ovr_r <= ovr_s;
      rdy_r <= (state_s == ST_WAIT_ACK);
    end
  end

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (ADDR_W)
  ) u_buf (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .wr_en   (wr_en_s),
    .wr_addr (idx_r[ADDR_W-1:0]),
    .wr_data (i_RX_Byte),
    .rd_addr (i_Rd_Addr),
    .rd_data (o_Rd_Data)
  );

  assign o_Pkt_Rdy = rdy_r;
  assign o_Pkt_Len = len_r;
  assign o_Pkt_Err = err_r;
  assign o_Overrun = ovr_r;

endmodule
